ram_arbiter: RTL and testbench

Two-port arbiter that shares the single-port 32x8 data RAM between the CPU datapath (port 0) and the program loader/DMA engine (port 1). Each requester issues one read or write at a time over a req/done handshake. The arbiter picks a winner round-robin, latches its operands, drives the RAM for exactly one cycle, and returns read data with a one-cycle done pulse. It sits directly in front of the RAM; neither requester touches RAM pins.

---
 rtl/ram_arb_pkg.sv | 19 +
 rtl/rr_pick.sv | 33 +++
 rtl/ram_arbiter.sv | 150 +++++++++++++++
 tb/tb_ram_arbiter.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arb_pkg.sv
// rtl/ram_arb_pkg.sv - shared types and constants for the data RAM arbiter
// Contents:
//   state_e  arbiter FSM states (IDLE, ACCESS, DONE)
//   NPORTS   number of requesters sharing the RAM
//   RAM_AW   default RAM address width (32 entries)
//   RAM_DW   default RAM data width
package ram_arb_pkg;

  localparam int NPORTS = 2;
  localparam int RAM_AW = 5;
  localparam int RAM_DW = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker
// Ports:
//   req_i         request vector, one bit per requester
//   last_grant_i  id of the most recent winner
//   grant_o       id of the chosen requester (meaningful only with valid_o)
//   valid_o       at least one request is pending
module rr_pick #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] last_grant_i,
  output logic [IW-1:0] grant_o,
  output logic          valid_o
);

  // The search starts just after the last winner, so the requester that was
  // served most recently has the lowest priority in the next contention.
  always_comb begin
    logic [IW-1:0] idx;
    grant_o = '0;
    valid_o = 1'b0;
    idx     = '0;
    for (int k = 1; k <= N; k++) begin
      idx = IW'((int'(last_grant_i) + k) % N);
      if (!valid_o && req_i[idx]) begin
        grant_o = idx;
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - round-robin two-port arbiter in front of the 32x8 data RAM
// Ports:
//   clk, rst_n             system clock, asynchronous active-low reset
//   req0/we0/addr0/wdata0  port 0 (CPU datapath) request and operands
//   req1/we1/addr1/wdata1  port 1 (loader/DMA) request and operands
//   done0/done1            one-cycle completion pulse per port
//   rdata0/rdata1          last read data per port, held until its next read
//   busy                   arbiter is in ACCESS or DONE
//   ram_addr/ram_data_in   RAM address and write data (hold last latched value)
//   ram_we                 RAM write enable, only during ACCESS of a write
//   ram_data_out           combinational RAM read data for ram_addr
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int AW = RAM_AW,
  parameter int DW = RAM_DW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          done0,
  output logic          done1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic          busy,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_data_in,
  output logic          ram_we,
  input  logic [DW-1:0] ram_data_out
);

  localparam int PW = $clog2(NPORTS);

  state_e          state_q, state_d;
  logic [PW-1:0]   last_grant_q, last_grant_d;
  logic [PW-1:0]   lat_port_q, lat_port_d;
  logic            lat_we_q, lat_we_d;
  logic [AW-1:0]   lat_addr_q, lat_addr_d;
  logic [DW-1:0]   lat_wdata_q, lat_wdata_d;
  logic [DW-1:0]   rdata0_q, rdata0_d;
  logic [DW-1:0]   rdata1_q, rdata1_d;

  logic [NPORTS-1:0] req_vec;
  logic [PW-1:0]     pick_id;
  logic              pick_valid;

  assign req_vec = {req1, req0};

  rr_pick #(
    .N  (NPORTS),
    .IW (PW)
  ) u_pick (
    .req_i        (req_vec),
    .last_grant_i (last_grant_q),
    .grant_o      (pick_id),
    .valid_o      (pick_valid)
  );

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    lat_port_d   = lat_port_q;
    lat_we_d     = lat_we_q;
    lat_addr_d   = lat_addr_q;
    lat_wdata_d  = lat_wdata_q;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;

    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d      = ACCESS;
          last_grant_d = pick_id;
          lat_port_d   = pick_id;
          if (pick_id == PW'(0)) begin
            lat_we_d    = we0;
            lat_addr_d  = addr0;
            lat_wdata_d = wdata0;
          end else begin
            lat_we_d    = we1;
            lat_addr_d  = addr1;
            lat_wdata_d = wdata1;
          end
        end
      end
      ACCESS: begin
        state_d = DONE;
        // The RAM read is combinational on ram_addr, so the data is ready
        // within ACCESS and is captured on the edge that leaves it.
        if (!lat_we_q) begin
          if (lat_port_q == PW'(0)) begin
            rdata0_d = ram_data_out;
          end else begin
            rdata1_d = ram_data_out;
          end
        end
      end
      DONE: begin
        // Requests are deliberately not sampled here; a held req is taken
        // as a fresh request in the following IDLE cycle.
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      // Port 1 counts as the last winner so port 0 wins the first contention.
      last_grant_q <= PW'(NPORTS - 1);
      lat_port_q   <= '0;
      lat_we_q     <= 1'b0;
      lat_addr_q   <= '0;
      lat_wdata_q  <= '0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      lat_port_q   <= lat_port_d;
      lat_we_q     <= lat_we_d;
      lat_addr_q   <= lat_addr_d;
      lat_wdata_q  <= lat_wdata_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
    end
  end

  // ram_we decodes from the state register, so an asynchronous reset in
  // ACCESS removes the write strobe before the next clock edge.
  assign ram_we      = (state_q == ACCESS) && lat_we_q;
  assign ram_addr    = lat_addr_q;
  assign ram_data_in = lat_wdata_q;
  assign done0       = (state_q == DONE) && (lat_port_q == PW'(0));
  assign done1       = (state_q == DONE) && (lat_port_q == PW'(1));
  assign busy        = (state_q != IDLE);
  assign rdata0      = rdata0_q;
  assign rdata1      = rdata1_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - self-checking bench for ram_arbiter
module tb_ram_arbiter;

  logic       clk;
  logic       rst_n;
  logic [1:0] req;
  logic [1:0] we;
  logic [4:0] addr [2];
  logic [7:0] wdata [2];
  logic       done0, done1, busy, ram_we;
  logic [7:0] rdata0, rdata1, ram_data_in, ram_data_out;
  logic [4:0] ram_addr;
  logic [1:0] dn;

  logic [7:0] mem [32];
  logic       load_mem;

  int checks;
  int failures;

  typedef struct {
    int         port;
    bit         wr;
    logic [4:0] a;
    logic [7:0] d;
    logic [7:0] exp_rd0;
    logic [7:0] exp_rd1;
  } vec_t;

  vec_t vecs [7];

  ram_arbiter dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req0         (req[0]),
    .req1         (req[1]),
    .we0          (we[0]),
    .we1          (we[1]),
    .addr0        (addr[0]),
    .addr1        (addr[1]),
    .wdata0       (wdata[0]),
    .wdata1       (wdata[1]),
    .done0        (done0),
    .done1        (done1),
    .rdata0       (rdata0),
    .rdata1       (rdata1),
    .busy         (busy),
    .ram_addr     (ram_addr),
    .ram_data_in  (ram_data_in),
    .ram_we       (ram_we),
    .ram_data_out (ram_data_out)
  );

  assign dn = {done1, done0};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port RAM: combinational read, write on the rising edge.
  assign ram_data_out = mem[ram_addr];
  always @(posedge clk) begin
    if (load_mem) begin
      for (int i = 0; i < 32; i++) mem[i] <= 8'hC0 | 8'(i);
    end else if (ram_we) begin
      mem[ram_addr] <= ram_data_in;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int lat;
    int wec;
    bit seen;
    int op;
    op  = 1 - v.port;
    lat = 0;
    wec = 0;
    seen = 1'b0;
    req[v.port]   = 1'b1;
    we[v.port]    = v.wr;
    addr[v.port]  = v.a;
    wdata[v.port] = v.d;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (ram_we) wec++;
      if (c == 1) begin
        check($sformatf("v%0d_ram_addr", idx), 32'(ram_addr), 32'(v.a));
        check($sformatf("v%0d_busy_access", idx), 32'(busy), 32'd1);
      end
      check($sformatf("v%0d_c%0d_other_done", idx, c), 32'(dn[op]), 32'd0);
      if (!seen && dn[v.port]) begin
        seen = 1'b1;
        lat  = c;
        req[v.port] = 1'b0;
      end
    end
    req[v.port] = 1'b0;
    check($sformatf("v%0d_latency", idx), 32'(lat), 32'd2);
    check($sformatf("v%0d_we_cycles", idx), 32'(wec), v.wr ? 32'd1 : 32'd0);
    check($sformatf("v%0d_rdata0", idx), 32'(rdata0), 32'(v.exp_rd0));
    check($sformatf("v%0d_rdata1", idx), 32'(rdata1), 32'(v.exp_rd1));
    check($sformatf("v%0d_busy_idle", idx), 32'(busy), 32'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_ram_we"}, 32'(ram_we), 32'd0);
    check({tag, "_ram_addr"}, 32'(ram_addr), 32'd0);
    check({tag, "_ram_data_in"}, 32'(ram_data_in), 32'd0);
    check({tag, "_done"}, 32'(dn), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_rdata0"}, 32'(rdata0), 32'd0);
    check({tag, "_rdata1"}, 32'(rdata1), 32'd0);
  endtask

  logic [1:0] exp_d;
  logic [7:0] ref_mem [32];
  logic [7:0] exp_rd [2];
  int         cd, busy_left, m_last, m_port, win;
  bit         m_rd;
  logic [7:0] m_val;
  vec_t       v7;

  initial begin
    checks   = 0;
    failures = 0;
    req      = 2'b00;
    we       = 2'b00;
    addr[0]  = '0; addr[1]  = '0;
    wdata[0] = '0; wdata[1] = '0;
    load_mem = 1'b1;
    rst_n    = 1'b0;

    vecs[0] = '{0, 1'b1, 5'd1,  8'hAA, 8'h00, 8'h00};
    vecs[1] = '{0, 1'b0, 5'd1,  8'h00, 8'hAA, 8'h00};
    vecs[2] = '{0, 1'b0, 5'd3,  8'h00, 8'h11, 8'h00};
    vecs[3] = '{1, 1'b0, 5'd4,  8'h00, 8'h11, 8'h22};
    vecs[4] = '{1, 1'b1, 5'd31, 8'hFF, 8'h11, 8'h22};
    vecs[5] = '{0, 1'b0, 5'd31, 8'h00, 8'hFF, 8'h22};
    vecs[6] = '{1, 1'b0, 5'd0,  8'h00, 8'hFF, 8'hC0};

    @(negedge clk);
    @(negedge clk);
    load_mem = 1'b0;
    check_reset_vals("por");
    rst_n = 1'b1;

    // Simultaneous writes right after reset: port 0 first, port 1 next.
    req = 2'b11; we = 2'b11;
    addr[0] = 5'd3; wdata[0] = 8'h11;
    addr[1] = 5'd4; wdata[1] = 8'h22;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      exp_d = (c == 2) ? 2'b01 : (c == 5) ? 2'b10 : 2'b00;
      check($sformatf("both_c%0d_done", c), 32'(dn), 32'(exp_d));
      if (c == 1) check("both_addr_p0", 32'(ram_addr), 32'd3);
      if (c == 4) check("both_addr_p1", 32'(ram_addr), 32'd4);
      if (c == 2) req[0] = 1'b0;
      if (c == 5) req[1] = 1'b0;
    end

    for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

    // Port 1 drops req once ACCESS has started.
    req[1] = 1'b1; we[1] = 1'b0; addr[1] = 5'd31;
    @(negedge clk);
    check("drop_busy", 32'(busy), 32'd1);
    req[1] = 1'b0;
    @(negedge clk);
    check("drop_done", 32'(dn), 32'b10);
    check("drop_rdata1", 32'(rdata1), 32'hFF);
    check("drop_rdata0", 32'(rdata0), 32'hFF);
    for (int c = 3; c <= 6; c++) begin
      @(negedge clk);
      check($sformatf("drop_c%0d_quiet", c), 32'({busy, dn}), 32'd0);
    end

    // Reset asserted in the middle of a write ACCESS.
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 5'd7; wdata[0] = 8'h55;
    @(negedge clk);
    check("rst_pre_we", 32'(ram_we), 32'd1);
    rst_n  = 1'b0;
    req[0] = 1'b0;
    #1;
    check_reset_vals("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      check($sformatf("midrst_c%0d_nodone", c), 32'(dn), 32'd0);
    end
    v7 = '{0, 1'b0, 5'd7, 8'h00, 8'hC7, 8'h00};
    run_vec(7, v7);

    // Continuous reads from both ports after a fresh reset.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    req = 2'b11; we = 2'b00;
    addr[0] = 5'd1; addr[1] = 5'd4;
    for (int c = 1; c <= 18; c++) begin
      @(negedge clk);
      exp_d = 2'b00;
      if (c % 3 == 2) exp_d[(c / 3) % 2] = 1'b1;
      check($sformatf("alt_c%0d_done", c), 32'(dn), 32'(exp_d));
    end
    req = 2'b00;
    @(negedge clk);
    @(negedge clk);
    check("alt_rdata0", 32'(rdata0), 32'hAA);
    check("alt_rdata1", 32'(rdata1), 32'h22);
    check("alt_busy", 32'(busy), 32'd0);

    // Randomized traffic against a transaction-level reference.
    for (int i = 0; i < 32; i++) ref_mem[i] = mem[i];
    exp_rd[0] = 8'hAA;
    exp_rd[1] = 8'h22;
    m_last    = 1;
    m_port    = 0;
    cd        = 0;
    busy_left = 0;
    m_rd      = 1'b0;
    m_val     = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      exp_d = 2'b00;
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          exp_d[m_port] = 1'b1;
          if (m_rd) exp_rd[m_port] = m_val;
        end
      end
      check($sformatf("rnd%0d_done", cyc), 32'(dn), 32'(exp_d));
      check($sformatf("rnd%0d_rdata0", cyc), 32'(rdata0), 32'(exp_rd[0]));
      check($sformatf("rnd%0d_rdata1", cyc), 32'(rdata1), 32'(exp_rd[1]));
      for (int p = 0; p < 2; p++) begin
        if (exp_d[p]) req[p] = 1'b0;
        if (!req[p] && cyc < 360 && $urandom_range(0, 2) != 0) begin
          req[p]   = 1'b1;
          we[p]    = 1'($urandom_range(0, 1));
          addr[p]  = 5'($urandom_range(0, 31));
          wdata[p] = 8'($urandom_range(0, 255));
        end
      end
      // Requests are sampled only when no transaction occupies the RAM;
      // a grant keeps it occupied for the two following edges.
      if (busy_left > 0) begin
        busy_left--;
      end else if (req != 2'b00) begin
        if (req == 2'b11) win = 1 - m_last;
        else              win = req[1] ? 1 : 0;
        m_last    = win;
        m_port    = win;
        cd        = 2;
        busy_left = 2;
        m_rd      = !we[win];
        if (we[win]) ref_mem[addr[win]] = wdata[win];
        else         m_val = ref_mem[addr[win]];
      end
    end
    check("rnd_drain_busy", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
